// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 memory path: arbiter FSM states and watchdog width.
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } arb_state_e;

  localparam int unsigned WDOG_W = 8;

endpackage

// File: rtl/rv32_wdog_counter.sv
// Bus watchdog: counts stalled cycles and flags the cycle whose count reaches the limit.
module rv32_wdog_counter
  import rv32_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [WDOG_W-1:0] limit,
  output logic              expired
);

  logic [WDOG_W-1:0] count_q, count_d;
  logic [WDOG_W:0]   count_inc;

  // expired looks ahead so the owner is released on the edge the count lands on limit
  always_comb begin
    count_inc = {1'b0, count_q} + {{WDOG_W{1'b0}}, 1'b1};
    expired   = enable && (count_inc >= {1'b0, limit});
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_inc[WDOG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port with a
// bus watchdog; all outputs are registered.
module rv32_mem_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned DATA_PRIO = 1,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ready,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ready,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_rdata
);

  localparam logic [WDOG_W-1:0] TO_LIMIT = WDOG_W'(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic            last_d_q, last_d_d;
  logic            m_req_q, m_req_d, m_we_q, m_we_d;
  logic [DW/8-1:0] m_be_q, m_be_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            i_ready_q, i_ready_d, i_err_q, i_err_d;
  logic            d_ready_q, d_ready_d, d_err_q, d_err_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic            i_elig, d_elig, grant_i, grant_d, grant, done, wd_en, wd_expired;
  logic [DW-1:0]   resp_data;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ready_d = 1'b0;
    i_rdata_d = '0;
    i_err_d   = 1'b0;
    d_ready_d = 1'b0;
    d_rdata_d = '0;
    d_err_d   = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    resp_data = '0;
    // a requester whose ready is pulsing this cycle is still holding req; skip it once
    i_elig    = i_req && !i_ready_q;
    d_elig    = d_req && !d_ready_q;
    wd_en     = m_req_q && !m_ack;

    case (state_q)
      IDLE: begin
        if (i_elig && d_elig) begin
          if (DATA_PRIO != 0 || !last_d_q) grant_d = 1'b1;
          else                             grant_i = 1'b1;
        end else begin
          grant_d = d_elig;
          grant_i = i_elig;
        end
        if (grant_d) begin
          state_d   = DBUS;
          last_d_d  = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_be_d    = d_be;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d   = IBUS;
          last_d_d  = 1'b0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = '1;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
        end
      end
      IBUS, DBUS: begin
        done      = m_ack || wd_expired;
        resp_data = (m_ack && !m_we_q) ? m_rdata : '0;
        if (done) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          if (state_q == DBUS) begin
            d_ready_d = 1'b1;
            d_rdata_d = resp_data;
            d_err_d   = !m_ack;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = resp_data;
            i_err_d   = !m_ack;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    grant = grant_i || grant_d;
  end

  rv32_wdog_counter u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (grant),
    .enable  (wd_en),
    .limit   (TO_LIMIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ready_q <= 1'b0;
      i_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_ready_q <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ready_q <= i_ready_d;
      i_rdata_q <= i_rdata_d;
      i_err_q   <= i_err_d;
      d_ready_q <= d_ready_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ready = i_ready_q;
  assign i_rdata = i_rdata_q;
  assign i_err   = i_err_q;
  assign d_ready = d_ready_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: a fixed-priority and a round-robin instance share stimulus;
// each scenario drives the selected instance and checks it against a transaction-level model.
module tb_rv32_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, m_rdata = '0;
  logic [BW-1:0] d_be = '0;

  logic          fp_i_ready, fp_i_err, fp_d_ready, fp_d_err, fp_m_req, fp_m_we;
  logic          rr_i_ready, rr_i_err, rr_d_ready, rr_d_err, rr_m_req, rr_m_we;
  logic [DW-1:0] fp_i_rdata, fp_d_rdata, fp_m_wdata, rr_i_rdata, rr_d_rdata, rr_m_wdata;
  logic [AW-1:0] fp_m_addr, rr_m_addr;
  logic [BW-1:0] fp_m_be, rr_m_be;

  // view of the instance under test: 0 = fixed data priority, 1 = round-robin
  bit            sel = 1'b0;
  logic          i_ready_v, i_err_v, d_ready_v, d_err_v, m_req_v, m_we_v;
  logic [DW-1:0] i_rdata_v, d_rdata_v, m_wdata_v;
  logic [AW-1:0] m_addr_v;
  logic [BW-1:0] m_be_v;

  assign i_ready_v = sel ? rr_i_ready : fp_i_ready;
  assign i_err_v   = sel ? rr_i_err   : fp_i_err;
  assign i_rdata_v = sel ? rr_i_rdata : fp_i_rdata;
  assign d_ready_v = sel ? rr_d_ready : fp_d_ready;
  assign d_err_v   = sel ? rr_d_err   : fp_d_err;
  assign d_rdata_v = sel ? rr_d_rdata : fp_d_rdata;
  assign m_req_v   = sel ? rr_m_req   : fp_m_req;
  assign m_we_v    = sel ? rr_m_we    : fp_m_we;
  assign m_be_v    = sel ? rr_m_be    : fp_m_be;
  assign m_addr_v  = sel ? rr_m_addr  : fp_m_addr;
  assign m_wdata_v = sel ? rr_m_wdata : fp_m_wdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          last_d  = 1'b0;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.AW(AW), .DW(DW), .DATA_PRIO(1), .TIMEOUT(TMO)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(fp_i_ready), .i_rdata(fp_i_rdata), .i_err(fp_i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(fp_d_ready), .d_rdata(fp_d_rdata), .d_err(fp_d_err),
    .m_req(fp_m_req), .m_we(fp_m_we), .m_be(fp_m_be), .m_addr(fp_m_addr), .m_wdata(fp_m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  rv32_mem_arbiter #(.AW(AW), .DW(DW), .DATA_PRIO(0), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(rr_i_ready), .i_rdata(rr_i_rdata), .i_err(rr_i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(rr_d_ready), .d_rdata(rr_d_rdata), .d_err(rr_d_err),
    .m_req(rr_m_req), .m_we(rr_m_we), .m_be(rr_m_be), .m_addr(rr_m_addr), .m_wdata(rr_m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  task automatic apply_reset();
    reset_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    last_d  = 1'b0;
    @(negedge clk);
  endtask

  // Memory side of one transaction; entered at the negedge where the grant should be visible.
  task automatic serve(input bit own_d, input int unsigned dly, input bit rand_rd,
                       input logic [DW-1:0] rdv, input string tag);
    int unsigned   n, exp_n;
    bit            exp_err;
    logic          ew;
    logic [BW-1:0] eb;
    logic [AW-1:0] ea;
    logic [DW-1:0] rd, exp_rd;
    ea      = own_d ? d_addr : i_addr;
    ew      = own_d ? d_we : 1'b0;
    eb      = own_d ? d_be : '1;
    exp_err = (dly >= TMO);
    exp_n   = exp_err ? TMO : dly + 1;
    rd      = '0;
    n       = 0;
    n_tests++;
    if (m_req_v !== 1'b1) begin
      n_fail++;
      $display("FAIL %s grant: m_req=%b required 1", tag, m_req_v);
    end
    while (m_req_v === 1'b1 && n < 3 * TMO) begin
      n_tests++;
      if (m_we_v !== ew || m_be_v !== eb || m_addr_v !== ea || (own_d && m_wdata_v !== d_wdata)) begin
        n_fail++;
        $display("FAIL %s cmd: we=%b be=%h addr=%h wdata=%h required we=%b be=%h addr=%h wdata=%h",
                 tag, m_we_v, m_be_v, m_addr_v, m_wdata_v, ew, eb, ea, d_wdata);
      end
      m_rdata = rand_rd ? $urandom : rdv;
      m_ack   = (n == dly);
      if (m_ack) rd = m_rdata;
      @(negedge clk);
      m_ack = 1'b0;
      n++;
    end
    n_tests++;
    if (n != exp_n) begin
      n_fail++;
      $display("FAIL %s m_req cycles: got %0d required %0d", tag, n, exp_n);
    end
    exp_rd = (exp_err || ew) ? '0 : rd;
    n_tests++;
    if (own_d) begin
      if (d_ready_v !== 1'b1 || d_rdata_v !== exp_rd || d_err_v !== exp_err ||
          i_ready_v !== 1'b0 || i_rdata_v !== '0 || i_err_v !== 1'b0) begin
        n_fail++;
        $display("FAIL %s d resp: rdy=%b rdata=%h err=%b i_rdy=%b required 1 %h %b 0",
                 tag, d_ready_v, d_rdata_v, d_err_v, i_ready_v, exp_rd, exp_err);
      end
      d_req = 1'b0;
    end else begin
      if (i_ready_v !== 1'b1 || i_rdata_v !== exp_rd || i_err_v !== exp_err ||
          d_ready_v !== 1'b0 || d_rdata_v !== '0 || d_err_v !== 1'b0) begin
        n_fail++;
        $display("FAIL %s i resp: rdy=%b rdata=%h err=%b d_rdy=%b required 1 %h %b 0",
                 tag, i_ready_v, i_rdata_v, i_err_v, d_ready_v, exp_rd, exp_err);
      end
      i_req = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (i_ready_v !== 1'b0 || d_ready_v !== 1'b0 || i_rdata_v !== '0 || d_rdata_v !== '0 ||
        i_err_v !== 1'b0 || d_err_v !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse end: i=%b/%h d=%b/%h required 0", tag, i_ready_v, i_rdata_v,
               d_ready_v, d_rdata_v);
    end
    last_d = own_d;
  endtask

  // Reference arbitration: data wins a tie when fixed, else whoever was not granted last.
  task automatic round(input bit ri, input bit rq, input int unsigned dly_i,
                       input int unsigned dly_d, input string tag);
    bit first_d;
    i_addr  = $urandom;
    d_addr  = $urandom;
    d_we    = $urandom_range(0, 1);
    d_be    = BW'($urandom);
    d_wdata = $urandom;
    i_req   = ri;
    d_req   = rq;
    first_d = rq && (!ri || !sel || !last_d);
    @(negedge clk);
    serve(first_d, first_d ? dly_d : dly_i, 1'b1, '0, tag);
    if (ri && rq) serve(!first_d, first_d ? dly_i : dly_d, 1'b1, '0, tag);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      n_tests++;
      if ({i_ready_v, i_err_v, d_ready_v, d_err_v, m_req_v, m_we_v} !== 6'b0 || i_rdata_v !== '0 ||
          d_rdata_v !== '0 || m_wdata_v !== '0 || m_addr_v !== '0 || m_be_v !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: m_req=%b m_addr=%h i_rdy=%b d_rdy=%b required all 0",
                 s, m_req_v, m_addr_v, i_ready_v, d_ready_v);
      end
    end
    sel = 1'b0;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      m_ack   = 1'b1;
      m_rdata = $urandom;
      @(negedge clk);
      n_tests++;
      if (m_req_v !== 1'b0 || i_ready_v !== 1'b0 || d_ready_v !== 1'b0) begin
        n_fail++;
        $display("FAIL idle ack: m_req=%b i_rdy=%b d_rdy=%b required 0", m_req_v, i_ready_v, d_ready_v);
      end
    end
    m_ack = 1'b0;
  endtask

  task automatic test_single_fetch();
    sel = 1'b0;
    apply_reset();
    i_addr = 32'h0000_0100;
    i_req  = 1'b1;
    @(negedge clk);
    serve(1'b0, 0, 1'b0, 32'h0000_0013, "fetch");
  endtask

  task automatic test_tie_fixed();
    sel = 1'b0;
    apply_reset();
    i_addr  = 32'h0000_0200;
    d_addr  = 32'h0000_2000;
    d_wdata = 32'hDEAD_BEEF;
    d_be    = 4'hF;
    d_we    = 1'b1;
    i_req   = 1'b1;
    d_req   = 1'b1;
    @(negedge clk);
    serve(1'b1, 1, 1'b1, '0, "tie_fp_d");
    serve(1'b0, 0, 1'b1, '0, "tie_fp_i");
  endtask

  task automatic test_rr_alternation();
    sel = 1'b1;
    apply_reset();
    round(1'b1, 1'b1, 0, 0, "rr_tie1");
    round(1'b1, 1'b1, 1, 2, "rr_tie2");
    round(1'b0, 1'b1, 0, 0, "rr_donly");
    round(1'b1, 1'b1, 0, 1, "rr_tie3");
  endtask

  task automatic test_timeout();
    sel = 1'b0;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      d_addr = $urandom;
      d_be   = BW'($urandom);
      d_we   = 1'b0;
      d_req  = 1'b1;
      @(negedge clk);
      case (k)
        0:       serve(1'b1, 100, 1'b1, '0, "timeout");
        1:       serve(1'b1, TMO - 1, 1'b0, 32'hCAFE_F00D, "ack_at_limit");
        default: serve(1'b1, TMO, 1'b1, '0, "ack_after_limit");
      endcase
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    apply_reset();
    i_addr = $urandom;
    i_req  = 1'b1;
    @(negedge clk);
    m_ack   = 1'b1;
    m_rdata = $urandom;
    @(negedge clk);
    m_ack = 1'b0;
    n_tests++;
    if (i_ready_v !== 1'b1 || m_req_v !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b first: i_rdy=%b m_req=%b required 1 0", i_ready_v, m_req_v);
    end
    @(negedge clk);
    n_tests++;
    if (m_req_v !== 1'b0 || i_ready_v !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b regrant in ready cycle: m_req=%b i_rdy=%b required 0 0", m_req_v, i_ready_v);
    end
    @(negedge clk);
    serve(1'b0, 0, 1'b1, '0, "b2b_second");
  endtask

  task automatic test_reset_midop();
    sel = 1'b0;
    apply_reset();
    d_addr = $urandom;
    d_we   = 1'b0;
    d_be   = 4'hF;
    d_req  = 1'b1;
    @(negedge clk);
    n_tests++;
    if (m_req_v !== 1'b1) begin
      n_fail++;
      $display("FAIL midop grant: m_req=%b required 1", m_req_v);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (m_req_v !== 1'b0 || m_addr_v !== '0 || m_be_v !== '0 || d_ready_v !== 1'b0 ||
        d_rdata_v !== '0 || i_ready_v !== 1'b0) begin
      n_fail++;
      $display("FAIL midop async: m_req=%b m_addr=%h m_be=%h d_rdy=%b required 0",
               m_req_v, m_addr_v, m_be_v, d_ready_v);
    end
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (d_ready_v !== 1'b0 || m_req_v !== 1'b0) begin
        n_fail++;
        $display("FAIL midop held: d_rdy=%b m_req=%b required 0", d_ready_v, m_req_v);
      end
    end
    reset_n = 1'b1;
    last_d  = 1'b0;
    @(negedge clk);
    serve(1'b1, 2, 1'b1, '0, "midop_regrant");
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      apply_reset();
      for (int r = 0; r < 30; r++) begin
        int unsigned kind, di, dd;
        repeat ($urandom_range(0, 2)) begin
          m_ack   = $urandom_range(0, 1);
          m_rdata = $urandom;
          @(negedge clk);
          n_tests++;
          if (m_req_v !== 1'b0 || i_ready_v !== 1'b0 || d_ready_v !== 1'b0) begin
            n_fail++;
            $display("FAIL rand idle[%0d]: m_req=%b i_rdy=%b d_rdy=%b required 0",
                     r, m_req_v, i_ready_v, d_ready_v);
          end
        end
        m_ack = 1'b0;
        kind  = $urandom_range(0, 2);
        di    = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 3);
        dd    = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 3);
        round(kind != 1, kind != 0, di, dd, sel ? "rand_rr" : "rand_fp");
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_tie_fixed();
    test_rr_alternation();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width; legal values are multiples of 8.
REQ-003 The block SHALL have parameter DATA_PRIO, default 1: 1 selects fixed data priority, 0 selects round-robin.
REQ-004 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum cycles to wait for m_ack; legal range is 1..255.
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request, held until i_ready
- i_addr  in  AW  fetch address
- i_ready  out  1  one-cycle fetch completion pulse
- i_rdata  out  DW  fetch data, valid with i_ready
- i_err  out  1  fetch timed out, valid with i_ready
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 means write
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ready  out  1  one-cycle data completion pulse
- d_rdata  out  DW  read data, valid with d_ready
- d_err  out  1  data timed out, valid with d_ready
- m_req  out  1  shared memory request
- m_we / m_be / m_addr / m_wdata  out  1 / DW/8 / AW / DW  registered command
- m_ack  in  1  memory completion, sampled only while m_req=1
- m_rdata  in  DW  memory read data, valid with m_ack

Function
REQ-006 The FSM SHALL have three states: IDLE, IBUS and DBUS.
REQ-007 In IDLE with a single requester, the FSM SHALL go to that requester's state on the next edge.
REQ-008 On entering IBUS or DBUS, the FSM SHALL register the winner's command into m_* and set m_req=1.
- For IBUS: m_we=0 and m_be all ones.
REQ-009 In IDLE with both requests and DATA_PRIO=1, data SHALL win.
REQ-010 In IDLE with both requests and DATA_PRIO=0, the requester not granted last SHALL win.
- The last-grant flag resets to "instruction", so data wins the first tie.
REQ-011 m_* SHALL stay stable while m_req=1.
REQ-012 On m_ack in IBUS/DBUS, the FSM SHALL, on the next edge:
- clear m_req;
- pulse the owner's ready for exactly one cycle;
- drive the owner's rdata with registered m_rdata (writes: 0);
- drive err=0;
- return to IDLE.
REQ-013 Minimum latency SHALL be 2 cycles from req to ready when m_ack arrives in the first cycle m_req=1.
REQ-014 A cycle counter SHALL clear on grant and increment each cycle m_req=1 without m_ack.
REQ-015 When the counter reaches TIMEOUT, the FSM SHALL clear m_req, pulse the owner's ready with err=1 and rdata=0, and return to IDLE.
REQ-016 An m_ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: completion is normal and err=0.
REQ-017 m_ack SHALL be ignored in IDLE.
REQ-018 ready/rdata/err of the non-owner SHALL stay 0; rdata SHALL be 0 outside its ready pulse.
REQ-019 A request still asserted in the cycle its own ready pulses SHALL NOT be re-granted that cycle.
- It becomes eligible on the cycle after the pulse.
REQ-020 Throughput SHALL be at most one transaction per 3 cycles per the FSM: grant, ack, ready/IDLE.

Reset
REQ-021 reset_n low SHALL asynchronously force:
- FSM to IDLE;
- counter to 0;
- last-grant flag to instruction;
- all outputs to 0.
REQ-022 Reset mid-transaction SHALL abort it with no ready pulse.
- After release, the FSM re-arbitrates pending requests from IDLE.

Structure
REQ-023 The state encoding (IDLE, IBUS, DBUS) SHALL live in shared package rv32_pkg for reuse by the multi-cycle core.
REQ-024 The timeout counter SHALL be one natural sub-module: rv32_wdog_counter (clear, enable, limit, expired).

Verification
REQ-025 Single fetch: i_req=1, i_addr=0x100, m_ack at the first m_req cycle with m_rdata=0x00000013 -> i_ready at cycle 2, i_rdata=0x00000013, i_err=0.
REQ-026 Tie with DATA_PRIO=1: i_req and d_req (write, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0xF) at the same time -> the first m_req carries m_we=1 and addr 0x2000; the fetch is served next.
REQ-027 Tie with DATA_PRIO=0: four back-to-back tied transactions -> grants alternate D, I, D, I.
REQ-028 Timeout: d_req read with m_ack never asserted and TIMEOUT=15 -> d_ready with d_err=1 and d_rdata=0 after 15 m_req cycles; m_req drops.
REQ-029 Ack at the limit: m_ack in the cycle the count hits TIMEOUT -> d_err=0 and data returned.
REQ-030 Reset mid-op: reset_n low while m_req=1 -> all outputs 0 immediately, no ready pulse; the held request is regranted after release.
